uart_tx_controller: RTL and testbench
=====================================

Name: uart_tx_controller

Overview:
Sequences the UART transmit path of the pipelined processor's UART peripheral. Accepts one byte per valid/ready handshake and frames it as start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits. Internally drives a loadable, set-on-reset shift register and a baud-rate counter. Sits between the memory-mapped UART register interface and the tx pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
tx_data  input  DATA_BITS  byte to send, sampled only on handshake
tx_valid  input  1  requester has a byte
tx_ready  output  1  controller can accept a byte (IDLE only)
tx_serial  output  1  serial line, idle high
tx_busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse on frame completion

Behaviour:
- Reset (async, any time, including mid-frame): tx_serial=1 immediately; tx_ready=1, tx_busy=0, tx_done=0; state=IDLE; counters=0; shift register all ones.
- Handshake: accept when tx_valid && tx_ready at a rising edge. Latch {stop bits=1, tx_data, start=0} into the shift register (parallel load). Baud counter clears. State goes to START.
- tx_valid while busy is ignored; it is neither queued nor an error. tx_data changes after acceptance have no effect.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx_serial=1.
  - START: tx_serial=0 for CLKS_PER_BIT cycles.
  - DATA: tx_serial=shift LSB. On each baud tick (counter == CLKS_PER_BIT-1), shift right with fill 1 and increment bit_idx. After DATA_BITS ticks, go to STOP.
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- tx_serial is registered and driven from the shift register LSB. It is glitch-free.
- Timing: the first start-bit cycle is the cycle after acceptance. The frame lasts exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_done is high for exactly the first IDLE cycle after STOP completes. tx_ready is also high in that cycle. Back-to-back acceptance in that cycle is legal and yields one extra idle-high cycle between frames.
- Baud counter: 0..CLKS_PER_BIT-1, wraps to 0 on tick. Held at 0 in IDLE. Width is $clog2(CLKS_PER_BIT).
- bit_idx width is $clog2(DATA_BITS+1). The stop counter is reused for 2-stop-bit frames.
- Elaboration assertion: CLKS_PER_BIT >= 2.
- Never outputs X after reset. tx_busy = !tx_ready at all times.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Default constants UART_CLKS_PER_BIT and UART_DATA_BITS, which the future receiver also uses.
- Sub-module uart_baud_counter: parameter CLKS_PER_BIT; ports clk, rst, clear, en, tick. Reused by the receiver.
- The shift register is inline; it is a vector of loadable flops, reset to 1.

Test Plan:
- CLKS_PER_BIT=4, send 0xA5: tx_serial holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles. tx_done pulses 40 cycles after acceptance. tx_busy is high for those 40 cycles.
- Reset asserted at cycle 13 of a 0x00 frame: tx_serial=1 the same cycle (async). tx_ready=1 and tx_done=0 after release. The next frame of 0xFF is correct.
- tx_valid held high continuously with 0x55 then 0x0F: both frames complete with one idle-high cycle between them. Mid-frame valid causes no corruption.
- STOP_BITS=2, CLKS_PER_BIT=3, send 0x80: the stop level lasts 6 cycles and the total frame is 33 cycles.
- tx_data toggled randomly during a frame of 0x3C: the serial output still encodes 0x3C, LSB first.
- Idle for 100 cycles with no valid: tx_serial=1, tx_ready=1, tx_done never asserts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and default link constants
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // 100 MHz system clock at 115200 baud
  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 while enabled and raises tick
// on the last cycle of each bit period, wrapping to 0 on that tick.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  // Bit-period counter; clear wins over counting so a new frame starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: accepts one word per valid/ready handshake and
// shifts out start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop
// bits. tx_serial is taken straight from the LSB flop of the shift register,
// so the line is glitch-free and returns high the instant reset asserts.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int FRAME_W = 1 + DATA_BITS + STOP_BITS;
  localparam int IDX_W   = $clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_controller: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_controller: STOP_BITS must be 1 or 2");
  end

  tx_state_t          state_reg, state_next;
  logic [FRAME_W-1:0] shift_reg, shift_next, frame_load;
  logic [IDX_W-1:0]   bit_idx_reg, bit_idx_next;
  logic               done_reg, done_next;
  logic               load, shift_en;
  logic               baud_clear, baud_en, baud_tick;

  assign tx_ready   = (state_reg == IDLE);
  assign tx_busy    = !tx_ready;
  assign tx_serial  = shift_reg[0];
  assign tx_done    = done_reg;

  assign frame_load = {{STOP_BITS{1'b1}}, tx_data, 1'b0};
  assign baud_clear = load || (state_reg == IDLE);
  assign baud_en    = (state_reg != IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .en   (baud_en),
    .tick (baud_tick)
  );

  // Per-bit next value: parallel load on handshake, shift right with 1 fill on tick
  for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_shift
    if (gi == FRAME_W - 1) begin : g_top
      assign shift_next[gi] = load ? frame_load[gi] : (shift_en ? 1'b1 : shift_reg[gi]);
    end else begin : g_mid
      assign shift_next[gi] = load ? frame_load[gi] : (shift_en ? shift_reg[gi+1] : shift_reg[gi]);
    end
  end

  // State, shift, bit index and done flop bank; shift register resets to all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '1;
      bit_idx_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic; bit_idx doubles as the stop-bit counter in STOP
  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    done_next    = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          load         = 1'b1;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (baud_tick) begin
          shift_en     = 1'b1;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_en = 1'b1;
          if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_next = '0;
            state_next   = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          shift_en = 1'b1;
          if (bit_idx_reg == IDX_W'(STOP_BITS - 1)) begin
            bit_idx_next = '0;
            done_next    = 1'b1;
            state_next   = IDLE;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed testbench for uart_tx_controller: one 8N1 instance at 4 clocks/bit
// and one 8N2 instance at 3 clocks/bit.
module tb_uart_tx_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_serial, tx_busy, tx_done;
  logic       tx_ready2, tx_serial2, tx_busy2, tx_done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_controller #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  uart_tx_controller #(.CLKS_PER_BIT(3), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data2),
    .tx_valid (tx_valid2),
    .tx_ready (tx_ready2),
    .tx_serial(tx_serial2),
    .tx_busy  (tx_busy2),
    .tx_done  (tx_done2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Serial level of frame bit b for an 8N1 frame of d: start, d LSB first, stop
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Called one cycle after the accepting edge; walks the 40-cycle frame and
  // ends in the first idle cycle, where tx_done must be high.
  task automatic check_frame(input logic [7:0] d, input bit toggle, input string name);
    for (int i = 0; i < 40; i++) begin
      if (toggle) tx_data = 8'($urandom);
      checks++;
      if (tx_serial !== frame_bit(d, i / 4)) begin
        errors++;
        $display("FAIL %s serial cycle %0d: got %b expected %b", name, i, tx_serial, frame_bit(d, i / 4));
      end
      checks++;
      if (tx_busy !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s status cycle %0d: got busy=%b done=%b ready=%b expected 1 0 0", name, i, tx_busy, tx_done, tx_ready);
      end
      step();
    end
    checks++;
    if (tx_done !== 1'b1 || tx_ready !== 1'b1 || tx_serial !== 1'b1) begin
      errors++;
      $display("FAIL %s end of frame: got done=%b ready=%b serial=%b expected 1 1 1", name, tx_done, tx_ready, tx_serial);
    end
    $display("frame %s data=%02h checked", name, d);
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic check_done_cleared(input string name);
    step();
    checks++;
    if (tx_done !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s done pulse width: got done=%b ready=%b expected 0 1", name, tx_done, tx_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = 8'h00; tx_data2 = 8'h00;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got serial=%b ready=%b busy=%b done=%b expected 1 1 0 0", tx_serial, tx_ready, tx_busy, tx_done);
    end
    checks++;
    if (tx_serial2 !== 1'b1 || tx_ready2 !== 1'b1 || tx_busy2 !== 1'b0 || tx_done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset state dut2: got serial=%b ready=%b busy=%b done=%b expected 1 1 0 0", tx_serial2, tx_ready2, tx_busy2, tx_done2);
    end
    $display("reset checked");
    step();
  endtask

  task automatic test_a5;
    logic [9:0] bits;
    bits = 10'b1101001010;  // bit 0 first: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (tx_serial !== bits[i/4] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL a5 cycle %0d: got serial=%b busy=%b done=%b expected %b 1 0", i, tx_serial, tx_busy, tx_done, bits[i/4]);
      end
      step();
    end
    checks++;
    if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL a5 done at cycle 40: got done=%b busy=%b expected 1 0", tx_done, tx_busy);
    end
    $display("frame a5 checked");
    check_done_cleared("a5");
  endtask

  task automatic test_reset_mid;
    send(8'h00);
    repeat (13) step();
    checks++;
    if (tx_serial !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset pre: got serial=%b busy=%b expected 0 1", tx_serial, tx_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset async: got serial=%b ready=%b busy=%b done=%b expected 1 1 0 0", tx_serial, tx_ready, tx_busy, tx_done);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (tx_ready !== 1'b1 || tx_done !== 1'b0 || tx_serial !== 1'b1) begin
      errors++;
      $display("FAIL midreset release: got ready=%b done=%b serial=%b expected 1 0 1", tx_ready, tx_done, tx_serial);
    end
    send(8'hFF);
    check_frame(8'hFF, 1'b0, "after_reset_ff");
    check_done_cleared("after_reset_ff");
  endtask

  task automatic test_back_to_back;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h0F;  // valid stays high through the whole first frame
    check_frame(8'h55, 1'b0, "b2b_55");
    step();           // accepted in the done cycle
    tx_valid = 1'b0;
    check_frame(8'h0F, 1'b0, "b2b_0f");
    check_done_cleared("b2b_0f");
  endtask

  task automatic test_random_data;
    send(8'h3C);
    check_frame(8'h3C, 1'b1, "toggle_3c");
    check_done_cleared("toggle_3c");
  endtask

  task automatic test_idle;
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL idle cycle %0d: got serial=%b ready=%b done=%b expected 1 1 0", i, tx_serial, tx_ready, tx_done);
      end
      step();
    end
    $display("idle 100 cycles checked");
  endtask

  task automatic test_two_stop;
    logic [10:0] bits;
    bits = 11'b11100000000;  // start, 0x80 LSB first, two stop bits
    tx_data2  = 8'h80;
    tx_valid2 = 1'b1;
    step();
    tx_valid2 = 1'b0;
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (tx_serial2 !== bits[i/3] || tx_busy2 !== 1'b1 || tx_done2 !== 1'b0) begin
        errors++;
        $display("FAIL two_stop cycle %0d: got serial=%b busy=%b done=%b expected %b 1 0", i, tx_serial2, tx_busy2, tx_done2, bits[i/3]);
      end
      step();
    end
    checks++;
    if (tx_done2 !== 1'b1 || tx_ready2 !== 1'b1 || tx_serial2 !== 1'b1) begin
      errors++;
      $display("FAIL two_stop done at cycle 33: got done=%b ready=%b serial=%b expected 1 1 1", tx_done2, tx_ready2, tx_serial2);
    end
    step();
    checks++;
    if (tx_done2 !== 1'b0) begin
      errors++;
      $display("FAIL two_stop done width: got %b expected 0", tx_done2);
    end
    $display("frame two_stop data=80 checked");
  endtask

  initial begin
    test_reset();
    test_a5();
    test_reset_mid();
    test_back_to_back();
    test_random_data();
    test_idle();
    test_two_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
